// File: rtl/regfile_dump_reader.sv
// Debug reader that walks the register file through one read port and streams
// a sync byte followed by every register, little-endian, on a valid/ready byte link.
module regfile_dump_reader #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_REGS      = 32,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDRESS_WIDTH-1:0] rd_id_o,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i
);

  localparam int unsigned BytesPerReg = DATA_WIDTH / 8;
  localparam int unsigned CntW        = (BytesPerReg > 1) ? $clog2(BytesPerReg) : 1;

  localparam logic [CntW-1:0]          LastByte = CntW'(BytesPerReg - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LastIdx  = ADDRESS_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StHeader, StLoad, StSend, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [CntW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    rd_id_o    = '0;
    tx_data_o  = '0;
    tx_valid_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StHeader;
      end
      StHeader: begin
        busy_o     = 1'b1;
        tx_valid_o = 1'b1;
        tx_data_o  = SYNC_BYTE;
        if (tx_ready_i) begin
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Capture point: later writes to this register do not affect its bytes.
        busy_o     = 1'b1;
        rd_id_o    = idx_q;
        shreg_d    = rd_data_i;
        byte_cnt_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        busy_o     = 1'b1;
        rd_id_o    = idx_q;
        tx_valid_o = 1'b1;
        tx_data_o  = shreg_q[7:0];
        if (tx_ready_i) begin
          shreg_d    = shreg_q >> 8;
          byte_cnt_d = byte_cnt_q + CntW'(1);
          if (byte_cnt_q == LastByte) begin
            if (idx_q == LastIdx) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + ADDRESS_WIDTH'(1);
              state_d = StLoad;
            end
          end
        end
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: byte stream, timing, stalls, restart,
// reset abort, capture semantics, and a single-register 8-bit configuration.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, tx_ready;
  logic        busy, done, tx_valid;
  logic [4:0]  rd_id;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic [31:0] regs [32];

  logic        start6, busy6, done6, tx_valid6;
  logic [4:0]  rd_id6;
  logic [7:0]  tx_data6;
  logic [7:0]  rd_data6;
  logic        tx_ready6;

  always #5 clk = ~clk;

  assign rd_data  = regs[rd_id];
  assign rd_data6 = 8'h5C;
  assign tx_ready6 = 1'b1;

  regfile_dump_reader u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .rd_id_o   (rd_id),
    .rd_data_i (rd_data),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready)
  );

  regfile_dump_reader #(
    .ADDRESS_WIDTH(5),
    .DATA_WIDTH   (8),
    .NUM_REGS     (1)
  ) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start6),
    .busy_o    (busy6),
    .done_o    (done6),
    .rd_id_o   (rd_id6),
    .rd_data_i (rd_data6),
    .tx_data_o (tx_data6),
    .tx_valid_o(tx_valid6),
    .tx_ready_i(tx_ready6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: captures transferred bytes, timing marks and stall stability.
  logic [7:0]  cap_q[$];
  int          n_done = 0;
  int          cyc = 0;
  int          t_hdr = 0, t_done = 0;
  int          gap = 0, gap_last = -1;
  bit          in_gap = 1'b0;
  logic        busy_prev = 1'b0, prev_stall = 1'b0, prev_rst = 1'b1;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (prev_stall && !prev_rst) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(prev_data));
    end
    if (!rst && tx_valid && tx_ready) cap_q.push_back(tx_data);
    if (busy && !busy_prev) t_hdr = cyc;
    if (done) begin
      n_done++;
      t_done = cyc;
      in_gap = 1'b1;
      gap    = 0;
    end else if (in_gap) begin
      if (!busy) gap++;
      else begin
        gap_last = gap;
        in_gap   = 1'b0;
      end
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_rst   = rst;
    busy_prev  = busy;
  end

  logic [31:0] model [32];
  logic [7:0]  exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int frames);
    exp_q.delete();
    repeat (frames) begin
      exp_q.push_back(8'hA5);
      for (int r = 0; r < 32; r++)
        for (int b = 0; b < 4; b++) exp_q.push_back(model[r][8*b +: 8]);
    end
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 32'(cap_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_mon();
    cap_q.delete();
    n_done = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
    tx_ready = 1'b1;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 32; i++) begin
      model[i] = {4{8'(i + 1)}};
      regs[i]  = model[i];
    end
    rst = 1'b1; start = 1'b0; start6 = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_rdid", 32'(rd_id), 32'd0);

    // T1: full-rate dump
    clear_mon();
    pulse_start();
    wait_done(1'b0, 400);
    build_exp(1);
    cmp_stream("t1_byte");
    check("t1_done_cnt", 32'(n_done), 32'd1);
    check("t1_latency", 32'(t_done - t_hdr), 32'd161);

    // T2: random backpressure
    clear_mon();
    pulse_start();
    wait_done(1'b1, 2000);
    cmp_stream("t2_byte");
    check("t2_done_cnt", 32'(n_done), 32'd1);

    // T3a: start while busy is ignored
    clear_mon();
    pulse_start();
    repeat (20) tick();
    pulse_start();
    wait_done(1'b0, 400);
    repeat (2) tick();
    cmp_stream("t3a_byte");
    check("t3a_done_cnt", 32'(n_done), 32'd1);
    check("t3a_idle", 32'(busy), 32'd0);

    // T3b: start held for 400 cycles -> three back-to-back frames
    clear_mon();
    start = 1'b1;
    repeat (400) tick();
    start = 1'b0;
    wait_done(1'b0, 400);
    repeat (2) tick();
    build_exp(3);
    cmp_stream("t3b_byte");
    check("t3b_done_cnt", 32'(n_done), 32'd3);
    check("t3b_gap", 32'(gap_last), 32'd1);
    check("t3b_idle", 32'(busy), 32'd0);

    // T4: reset during SEND of reg 7
    clear_mon();
    pulse_start();
    k = 0;
    while (!(rd_id == 5'd7 && tx_valid) && k < 200) begin
      tick();
      k++;
    end
    check("t4_reach", 32'(rd_id == 5'd7 && tx_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid", 32'(tx_valid), 32'd0);
    check("t4_rdid", 32'(rd_id), 32'd0);
    tick();
    clear_mon();
    pulse_start();
    wait_done(1'b0, 400);
    build_exp(1);
    cmp_stream("t4_byte");
    check("t4_done_cnt", 32'(n_done), 32'd1);

    // T5a: write to reg 3 after capture does not change streamed bytes
    clear_mon();
    pulse_start();
    k = 0;
    while (!(rd_id == 5'd3 && tx_valid) && k < 200) begin
      tick();
      k++;
    end
    check("t5a_reach", 32'(rd_id == 5'd3 && tx_valid), 32'd1);
    regs[3] = 32'hDEADBEEF;
    wait_done(1'b0, 400);
    cmp_stream("t5a_byte");

    // T5b: write during the reg-3 LOAD cycle is captured
    regs[3] = 32'h04040404;
    clear_mon();
    pulse_start();
    k = 0;
    while (!(rd_id == 5'd3 && !tx_valid && busy) && k < 200) begin
      tick();
      k++;
    end
    check("t5b_reach", 32'(rd_id == 5'd3 && !tx_valid && busy), 32'd1);
    regs[3]  = 32'hDEADBEEF;
    model[3] = 32'hDEADBEEF;
    wait_done(1'b0, 400);
    build_exp(1);
    cmp_stream("t5b_byte");

    // T6: one 8-bit register
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    check("t6_hdr_valid", 32'(tx_valid6), 32'd1);
    check("t6_hdr_data", 32'(tx_data6), 32'hA5);
    check("t6_hdr_busy", 32'(busy6), 32'd1);
    tick();
    check("t6_load_valid", 32'(tx_valid6), 32'd0);
    check("t6_load_rdid", 32'(rd_id6), 32'd0);
    tick();
    check("t6_send_valid", 32'(tx_valid6), 32'd1);
    check("t6_send_data", 32'(tx_data6), 32'h5C);
    tick();
    check("t6_done", 32'(done6), 32'd1);
    tick();
    check("t6_idle_done", 32'(done6), 32'd0);
    check("t6_idle_busy", 32'(busy6), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
